// File: rtl/aes_ctr_keystream_xor.sv
// CTR-mode keystream stage: drives an AES core and XORs its output into a 128-bit stream.
// Optional build macro AES_CTR_OVF_DETECT_EN adds a sticky counter-wrap flag that stalls the stream.
module aes_ctr_keystream_xor #(
    parameter int CTR_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] cfg_iv,
    input  logic         cfg_load,
    input  logic [127:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    input  logic         s_axis_tlast,
    output logic         s_axis_tready,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    output logic         m_axis_tlast,
    input  logic         m_axis_tready,
    output logic         enc_next,
    output logic [127:0] enc_block,
    input  logic         enc_ready,
    input  logic [127:0] enc_result,
    output logic         busy,
    output logic         ctr_ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GEN   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [127:0] LP_MASK =
        (CTR_W >= 128) ? {128{1'b1}} : ((128'd1 << CTR_W) - 128'd1);

    logic [1:0]   r_state;
    logic [127:0] r_ctr;
    logic [127:0] r_ks;
    logic         r_ks_valid;
    logic [127:0] r_mdata;
    logic         r_mvalid;
    logic         r_mlast;

    logic [127:0] w_ctr_inc;
    logic         w_ovf_blk;
    logic         w_accept;

    // Only the low CTR_W bits count; the nonce part is carried through untouched.
    assign w_ctr_inc = (r_ctr & ~LP_MASK) | ((r_ctr + 128'd1) & LP_MASK);

`ifdef AES_CTR_OVF_DETECT_EN
    logic r_ovf;
    logic w_wrap;

    assign w_wrap = (r_ctr & LP_MASK) == LP_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (cfg_load) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_WAIT && enc_ready && w_wrap) begin
            r_ovf <= 1'b1;
        end
    end

    assign w_ovf_blk = r_ovf;
    assign ctr_ovf   = r_ovf;
`else
    assign w_ovf_blk = 1'b0;
    assign ctr_ovf   = 1'b0;
`endif

    assign s_axis_tready = r_ks_valid & (~r_mvalid | m_axis_tready)
                         & ~cfg_load & ~w_ovf_blk;
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    assign m_axis_tdata  = r_mdata;
    assign m_axis_tvalid = r_mvalid;
    assign m_axis_tlast  = r_mlast;
    assign enc_next      = (r_state == S_GEN);
    assign enc_block     = r_ctr;
    assign busy          = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mdata  <= '0;
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
        end else if (w_accept) begin
            r_mdata  <= s_axis_tdata ^ r_ks;
            r_mlast  <= s_axis_tlast;
            r_mvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_mvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ctr      <= '0;
            r_ks       <= '0;
            r_ks_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_load) begin
                        r_ctr      <= cfg_iv;
                        r_ks_valid <= 1'b0;
                        r_state    <= S_GEN;
                    end else if (w_accept) begin
                        r_ks_valid <= 1'b0;
                        r_state    <= S_GEN;
                    end
                end
                S_GEN: begin
                    if (cfg_load) begin
                        r_ctr   <= cfg_iv;
                        r_state <= S_DRAIN;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cfg_load) begin
                        r_ctr   <= cfg_iv;
                        r_state <= S_DRAIN;
                    end else if (enc_ready) begin
                        r_ks       <= enc_result;
                        r_ks_valid <= 1'b1;
                        r_ctr      <= w_ctr_inc;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    // A core started before the reload is still running; wait it out.
                    if (cfg_load) begin
                        r_ctr <= cfg_iv;
                    end
                    if (enc_ready) begin
                        r_state <= S_GEN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ctr_keystream_xor.sv
// Directed bench for aes_ctr_keystream_xor with a behavioural AES core stand-in.
// The stand-in returns SP800-38A CTR keystream for the two NIST blocks and ~block otherwise.
module tb_aes_ctr_keystream_xor;

    localparam logic [127:0] IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] IV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] KS0 = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    localparam logic [127:0] KS1 = 128'h362b7c3c6773516318a077d7fc5073ae;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] IV2 = 128'h00000000000000000000000000001000;
    localparam logic [127:0] IV8 = 128'h000102030405060708090a0b0c0d0eff;
    localparam logic [127:0] B8N = 128'h000102030405060708090a0b0c0d0e00;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam int LAT = 4;

    logic         clk;
    logic         reset;
    logic [127:0] cfg_iv;
    logic         cfg_load;
    logic [127:0] s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic         enc_next;
    logic [127:0] enc_block;
    logic         enc_ready;
    logic [127:0] enc_result;
    logic         busy;
    logic         ctr_ovf;

    logic         cfg_load8;
    logic         s_tvalid8;
    logic         s_tready8;
    logic [127:0] m_tdata8;
    logic         m_tvalid8;
    logic         m_tlast8;
    logic         enc_next8;
    logic [127:0] enc_block8;
    logic         enc_ready8;
    logic [127:0] enc_result8;
    logic         busy8;
    logic         ctr_ovf8;

    int total;
    int bad;

    logic [127:0] blk;
    logic [127:0] blk8;
    int           cnt;
    int           cnt8;

    aes_ctr_keystream_xor dut (
        .clk(clk), .reset(reset), .cfg_iv(cfg_iv), .cfg_load(cfg_load),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .enc_next(enc_next), .enc_block(enc_block),
        .enc_ready(enc_ready), .enc_result(enc_result),
        .busy(busy), .ctr_ovf(ctr_ovf)
    );

    aes_ctr_keystream_xor #(.CTR_W(8)) dut8 (
        .clk(clk), .reset(reset), .cfg_iv(cfg_iv), .cfg_load(cfg_load8),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid8),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready8),
        .m_axis_tdata(m_tdata8), .m_axis_tvalid(m_tvalid8),
        .m_axis_tlast(m_tlast8), .m_axis_tready(m_tready),
        .enc_next(enc_next8), .enc_block(enc_block8),
        .enc_ready(enc_ready8), .enc_result(enc_result8),
        .busy(busy8), .ctr_ovf(ctr_ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] ks_of(input logic [127:0] b);
        if (b == IV) return KS0;
        if (b == IV1) return KS1;
        return ~b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            enc_ready <= 1'b1; enc_result <= '0; cnt <= 0; blk <= '0;
        end else if (enc_next) begin
            enc_ready <= 1'b0; cnt <= LAT; blk <= enc_block;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                enc_ready <= 1'b1; enc_result <= ks_of(blk);
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            enc_ready8 <= 1'b1; enc_result8 <= '0; cnt8 <= 0; blk8 <= '0;
        end else if (enc_next8) begin
            enc_ready8 <= 1'b0; cnt8 <= LAT; blk8 <= enc_block8;
        end else if (cnt8 != 0) begin
            cnt8 <= cnt8 - 1;
            if (cnt8 == 1) begin
                enc_ready8 <= 1'b1; enc_result8 <= ks_of(blk8);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input string name);
        int n = 0;
        while (!s_tready && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (s_tready !== 1'b1) begin
            bad++;
            $display("FAIL %s s_tready timeout got=%b exp=1", name, s_tready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({m_tvalid, m_tlast, s_tready, enc_next, busy, ctr_ovf} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {m_tvalid, m_tlast, s_tready, enc_next, busy, ctr_ovf});
        end
        total++;
        if (m_tdata !== 128'h0 || enc_block !== 128'h0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h exp=0/0", m_tdata, enc_block);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (enc_next !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_no_next got=%b%b exp=00", enc_next, busy);
            end
        end
    endtask

    task automatic test_vectors();
        m_tready = 1'b1;
        cfg_iv = IV;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        total++;
        if (enc_next !== 1'b1 || enc_block !== IV) begin
            bad++;
            $display("FAIL gen0 got=%b %h exp=1 %h", enc_next, enc_block, IV);
        end
        wait_rdy("vec1");
        s_tdata = P1; s_tvalid = 1'b1; s_tlast = 1'b0;
        tick();
        s_tvalid = 1'b0;
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== C1) begin
            bad++;
            $display("FAIL vec1 got=%b %h exp=1 %h", m_tvalid, m_tdata, C1);
        end
        total++;
        if (enc_next !== 1'b1 || enc_block !== IV1) begin
            bad++;
            $display("FAIL gen1 got=%b %h exp=1 %h", enc_next, enc_block, IV1);
        end
        wait_rdy("vec2");
        s_tdata = P2; s_tvalid = 1'b1; s_tlast = 1'b1;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        total++;
        if (m_tdata !== C2 || m_tlast !== 1'b1) begin
            bad++;
            $display("FAIL vec2 got=%h %b exp=%h 1", m_tdata, m_tlast, C2);
        end
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_a;
        logic [127:0] exp_b;
        exp_a = 128'h0f0e0d0c0b0a090807060504030200fe;
        exp_b = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02;
        m_tready = 1'b0;
        wait_rdy("bp_a");
        s_tdata = '0; s_tvalid = 1'b1; s_tlast = 1'b0;
        tick();
        s_tdata = ONES; s_tlast = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp_a || s_tready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold got=%b %h %b exp=1 %h 0",
                         m_tvalid, m_tdata, s_tready, exp_a);
            end
            tick();
        end
        m_tready = 1'b1;
        #1;
        total++;
        if (s_tready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got=%b exp=1", s_tready);
        end
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== exp_b || m_tlast !== 1'b1) begin
            bad++;
            $display("FAIL bp_b got=%b %h %b exp=1 %h 1",
                     m_tvalid, m_tdata, m_tlast, exp_b);
        end
        tick();
        total++;
        if (m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain got=%b exp=0", m_tvalid);
        end
    endtask

    task automatic test_load_wait();
        logic [127:0] exp_c;
        int n;
        exp_c = 128'h0f0e0d0c0b0a090807060504030200fc;
        wait_rdy("lw_c");
        s_tdata = '0; s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        total++;
        if (m_tdata !== exp_c || enc_next !== 1'b1) begin
            bad++;
            $display("FAIL lw_c got=%h %b exp=%h 1", m_tdata, enc_next, exp_c);
        end
        tick();
        cfg_iv = IV2; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        n = 0;
        while (!enc_ready && n < 30) begin
            total++;
            if (enc_next !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL lw_drain got=%b%b exp=01", enc_next, busy);
            end
            tick();
            n++;
        end
        total++;
        if (enc_ready !== 1'b1) begin
            bad++;
            $display("FAIL lw_ready timeout got=%b exp=1", enc_ready);
        end
        tick();
        total++;
        if (enc_next !== 1'b1 || enc_block !== IV2) begin
            bad++;
            $display("FAIL lw_gen got=%b %h exp=1 %h", enc_next, enc_block, IV2);
        end
        wait_rdy("lw_d");
        s_tdata = ONES; s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        total++;
        if (m_tdata !== IV2) begin
            bad++;
            $display("FAIL lw_d got=%h exp=%h", m_tdata, IV2);
        end
        tick();
    endtask

    task automatic test_wrap8();
        int n;
        cfg_iv = IV8; cfg_load8 = 1'b1;
        tick();
        cfg_load8 = 1'b0;
        total++;
        if (enc_next8 !== 1'b1 || enc_block8 !== IV8) begin
            bad++;
            $display("FAIL w8_gen got=%b %h exp=1 %h", enc_next8, enc_block8, IV8);
        end
        n = 0;
        while (busy8 && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (busy8 !== 1'b0 || enc_block8 !== B8N) begin
            bad++;
            $display("FAIL w8_inc got=%b %h exp=0 %h", busy8, enc_block8, B8N);
        end
`ifdef AES_CTR_OVF_DETECT_EN
        total++;
        if (ctr_ovf8 !== 1'b1 || s_tready8 !== 1'b0) begin
            bad++;
            $display("FAIL w8_ovf got=%b%b exp=10", ctr_ovf8, s_tready8);
        end
        s_tdata = ONES; s_tvalid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (enc_next8 !== 1'b0 || s_tready8 !== 1'b0 || m_tvalid8 !== 1'b0) begin
                bad++;
                $display("FAIL w8_stall got=%b%b%b exp=000",
                         enc_next8, s_tready8, m_tvalid8);
            end
        end
        s_tvalid8 = 1'b0;
        cfg_load8 = 1'b1;
        tick();
        cfg_load8 = 1'b0;
        total++;
        if (ctr_ovf8 !== 1'b0 || enc_next8 !== 1'b1) begin
            bad++;
            $display("FAIL w8_clear got=%b%b exp=01", ctr_ovf8, enc_next8);
        end
`else
        total++;
        if (ctr_ovf8 !== 1'b0 || s_tready8 !== 1'b1) begin
            bad++;
            $display("FAIL w8_noovf got=%b%b exp=01", ctr_ovf8, s_tready8);
        end
        s_tdata = ONES; s_tvalid8 = 1'b1;
        tick();
        s_tvalid8 = 1'b0;
        total++;
        if (m_tdata8 !== IV8 || enc_next8 !== 1'b1 || enc_block8 !== B8N) begin
            bad++;
            $display("FAIL w8_beat got=%h %b %h exp=%h 1 %h",
                     m_tdata8, enc_next8, enc_block8, IV8, B8N);
        end
`endif
    endtask

    task automatic test_reset_mid();
        m_tready = 1'b0;
        wait_rdy("rm");
        s_tdata = '0; s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        tick();
        total++;
        if (m_tvalid !== 1'b1 || busy !== 1'b1 || enc_next !== 1'b0) begin
            bad++;
            $display("FAIL rm_wait got=%b%b%b exp=110", m_tvalid, busy, enc_next);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({m_tvalid, busy, s_tready, enc_next} !== 4'b0 || m_tdata !== 128'h0) begin
            bad++;
            $display("FAIL rm_reset got=%b %h exp=0000 0",
                     {m_tvalid, busy, s_tready, enc_next}, m_tdata);
        end
        reset = 1'b0;
        m_tready = 1'b1;
        tick();
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; cfg_iv = '0; cfg_load = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        cfg_load8 = 1'b0; s_tvalid8 = 1'b0;
        #1;
        test_reset();
        test_vectors();
        test_backpressure();
        test_load_wait();
        test_wrap8();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
